// File: rtl/echo_estimator_if.sv
// Sample-stream bundle for echo_estimator: enable in, reference/echo/estimates out.
interface echo_estimator_if;
    logic        en;
    logic [15:0] signal_random;
    logic [19:0] signal_lag;
    logic [15:0] para_0;
    logic [15:0] para_1;
    logic [15:0] para_2;
    logic [19:0] err;

    // Driver side (bench or upstream controller)
    modport master (
        output en,
        input  signal_random,
        input  signal_lag,
        input  para_0,
        input  para_1,
        input  para_2,
        input  err
    );

    // Estimator side
    modport slave (
        input  en,
        output signal_random,
        output signal_lag,
        output para_0,
        output para_1,
        output para_2,
        output err
    );
endinterface

// File: rtl/echo_estimator.sv
// Echo-path source and sign-sign LMS coefficient estimator.
// An LFSR provides the reference x, a tapped delay line builds the synthetic
// echo y, and three Q4.12 weights track the echo coefficients.
module echo_estimator #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter int unsigned LAG  = 4,
    parameter int          C0   = 1,
    parameter int          C1   = 2,
    parameter int          C2   = -1,
    parameter int          STEP = 16
) (
    input logic              clk,
    input logic              rst_n,
    echo_estimator_if.slave  bus
);

    localparam int DEPTH = 2 * int'(LAG);
    localparam int TAP1  = int'(LAG) - 1;
    localparam int TAP2  = DEPTH - 1;

    logic [15:0]        lfsr_q;
    logic [15:0]        lfsr_d;
    logic signed [15:0] x;
    logic signed [15:0] dly_q [DEPTH];
    logic signed [19:0] y_q;
    logic signed [19:0] y_d;
    logic signed [15:0] xe_q [3];
    logic signed [15:0] w_q [3];
    logic signed [15:0] w_d [3];
    logic signed [19:0] err_q;
    logic signed [19:0] err_d;

    logic signed [33:0] acc;
    logic signed [33:0] yhat;
    logic signed [34:0] e;
    int                 e_sgn;
    int                 x_sgn [3];
    int                 w_sum [3];

    assign x = signed'(lfsr_q);

    // LFSR advance and synthetic echo from the current sample and two delayed taps
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        // Coefficients are small, so the full-precision sum always fits in 20 bits
        y_d    = 20'(C0 * 32'(x) + C1 * 32'(dly_q[TAP1]) + C2 * 32'(dly_q[TAP2]));
    end

    // Estimate, error and sign-sign weight update against the registered echo
    always_comb begin
        acc   = 34'(w_q[0]) * 34'(xe_q[0]) + 34'(w_q[1]) * 34'(xe_q[1])
              + 34'(w_q[2]) * 34'(xe_q[2]);
        yhat  = acc >>> 12;
        e     = 35'(y_q) - 35'(yhat);
        e_sgn = (e > 35'sd0) ? 1 : ((e < 35'sd0) ? -1 : 0);
        for (int k = 0; k < 3; k++) begin
            x_sgn[k] = (xe_q[k] > 16'sd0) ? 1 : ((xe_q[k] < 16'sd0) ? -1 : 0);
            w_sum[k] = 32'(w_q[k]) + e_sgn * x_sgn[k] * STEP;
            if (w_sum[k] > 32767) begin
                w_d[k] = 16'sh7fff;
            end else if (w_sum[k] < -32768) begin
                w_d[k] = 16'sh8000;
            end else begin
                w_d[k] = w_sum[k][15:0];
            end
        end
        // e can exceed 20 bits while the weights are far from the true echo
        if (e > 35'sd524287) begin
            err_d = 20'sh7ffff;
        end else if (e < -35'sd524288) begin
            err_d = 20'sh80000;
        end else begin
            err_d = e[19:0];
        end
    end

    // All state advances together on an enabled edge and holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
            y_q    <= '0;
            err_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dly_q[i] <= '0;
            end
            for (int k = 0; k < 3; k++) begin
                xe_q[k] <= '0;
                w_q[k]  <= '0;
            end
        end else if (bus.en) begin
            lfsr_q   <= lfsr_d;
            y_q      <= y_d;
            err_q    <= err_d;
            dly_q[0] <= x;
            for (int i = 1; i < DEPTH; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
            // Taps aligned with y_q so the estimate compares like with like
            xe_q[0] <= x;
            xe_q[1] <= dly_q[TAP1];
            xe_q[2] <= dly_q[TAP2];
            for (int k = 0; k < 3; k++) begin
                w_q[k] <= w_d[k];
            end
        end
    end

    assign bus.signal_random = lfsr_q;
    assign bus.signal_lag    = y_q;
    assign bus.para_0        = w_q[0];
    assign bus.para_1        = w_q[1];
    assign bus.para_2        = w_q[2];
    assign bus.err           = err_q;

endmodule

// File: tb/tb_echo_estimator.sv
// Directed bench for echo_estimator: a default instance and a zero-echo instance.
module tb_echo_estimator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    echo_estimator_if e_if ();
    echo_estimator_if z_if ();

    echo_estimator #(
        .SEED(16'hACE1), .LAG(4), .C0(1), .C1(2), .C2(-1), .STEP(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(e_if.slave)
    );

    echo_estimator #(
        .SEED(16'hACE1), .LAG(4), .C0(0), .C1(0), .C2(0), .STEP(16)
    ) dut_z (
        .clk(clk),
        .rst_n(rst_n),
        .bus(z_if.slave)
    );

    // Behavioural model of the default instance (LAG=4, C=1,2,-1, STEP=16)
    logic [15:0] m_q;
    int          m_d [8];
    int          m_xe [3];
    int          m_w [3];
    int          m_y;
    int          m_err;

    task automatic model_reset();
        m_q = 16'hACE1;
        for (int i = 0; i < 8; i++) m_d[i] = 0;
        for (int k = 0; k < 3; k++) begin
            m_xe[k] = 0;
            m_w[k]  = 0;
        end
        m_y   = 0;
        m_err = 0;
    endtask

    task automatic model_step();
        longint acc;
        longint e;
        int     xi;
        int     se;
        int     sx;
        int     nw;
        xi  = int'($signed(m_q));
        acc = 0;
        for (int k = 0; k < 3; k++) acc += longint'(m_w[k]) * longint'(m_xe[k]);
        e  = longint'(m_y) - (acc >>> 12);
        se = (e > 0) ? 1 : ((e < 0) ? -1 : 0);
        for (int k = 0; k < 3; k++) begin
            sx = (m_xe[k] > 0) ? 1 : ((m_xe[k] < 0) ? -1 : 0);
            nw = m_w[k] + se * sx * 16;
            if (nw > 32767) nw = 32767;
            if (nw < -32768) nw = -32768;
            m_w[k] = nw;
        end
        if (e > 524287) m_err = 524287;
        else if (e < -524288) m_err = -524288;
        else m_err = int'(e);
        m_y     = xi + 2 * m_d[3] - m_d[7];
        m_xe[0] = xi;
        m_xe[1] = m_d[3];
        m_xe[2] = m_d[7];
        for (int i = 7; i > 0; i--) m_d[i] = m_d[i-1];
        m_d[0] = xi;
        m_q = {m_q[14:0], m_q[15] ^ m_q[13] ^ m_q[12] ^ m_q[10]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_en(input logic v);
        e_if.en = v;
        z_if.en = v;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_en(1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        repeat (6) tick();
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (e_if.signal_random !== 16'hACE1) begin
            $display("FAIL reset_random: got %h want %h", e_if.signal_random, 16'hACE1);
            miscompares++;
        end
        vectors++;
        if (e_if.signal_lag !== 20'h0) begin
            $display("FAIL reset_lag: got %h want 0", e_if.signal_lag);
            miscompares++;
        end
        vectors++;
        if ({e_if.para_0, e_if.para_1, e_if.para_2} !== 48'h0) begin
            $display("FAIL reset_para: got %h %h %h want 0", e_if.para_0, e_if.para_1,
                     e_if.para_2);
            miscompares++;
        end
        vectors++;
        if (e_if.err !== 20'h0) begin
            $display("FAIL reset_err: got %h want 0", e_if.err);
            miscompares++;
        end
    endtask

    task automatic test_lfsr();
        logic [15:0] exp_seq [2];
        exp_seq[0] = 16'h59C3;
        exp_seq[1] = 16'hB387;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (e_if.signal_random !== exp_seq[i]) begin
                $display("FAIL lfsr_edge%0d: got %h want %h", i + 1, e_if.signal_random,
                         exp_seq[i]);
                miscompares++;
            end
        end
    endtask

    task automatic test_latency();
        apply_reset();
        tick();
        vectors++;
        if (e_if.signal_lag !== 20'hFACE1) begin
            $display("FAIL lag_edge1: got %h want FACE1", e_if.signal_lag);
            miscompares++;
        end
        vectors++;
        if (e_if.err !== 20'h0 || e_if.para_0 !== 16'h0) begin
            $display("FAIL est_edge1: got err=%h p0=%h want 0 0", e_if.err, e_if.para_0);
            miscompares++;
        end
        tick();
        vectors++;
        if (e_if.signal_lag !== 20'h059C3) begin
            $display("FAIL lag_edge2: got %h want 059C3", e_if.signal_lag);
            miscompares++;
        end
        vectors++;
        if (e_if.err !== 20'hFACE1) begin
            $display("FAIL err_edge2: got %h want FACE1", e_if.err);
            miscompares++;
        end
        vectors++;
        if (e_if.para_0 !== 16'd16 || e_if.para_1 !== 16'd0 || e_if.para_2 !== 16'd0) begin
            $display("FAIL para_edge2: got %h %h %h want 0010 0000 0000", e_if.para_0,
                     e_if.para_1, e_if.para_2);
            miscompares++;
        end
    endtask

    task automatic test_echo();
        int m_w0;
        int m_w1;
        int m_w2;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            model_step();
            tick();
            m_w0 = m_w[0];
            m_w1 = m_w[1];
            m_w2 = m_w[2];
            vectors++;
            if (e_if.signal_random !== m_q || e_if.signal_lag !== m_y[19:0]) begin
                $display("FAIL echo_cyc%0d: got x=%h y=%h want x=%h y=%h", i, e_if.signal_random,
                         e_if.signal_lag, m_q, m_y[19:0]);
                miscompares++;
            end
            vectors++;
            if (e_if.err !== m_err[19:0] || e_if.para_0 !== m_w0[15:0] ||
                e_if.para_1 !== m_w1[15:0] || e_if.para_2 !== m_w2[15:0]) begin
                $display("FAIL est_cyc%0d: got e=%h w=%h %h %h want e=%h w=%h %h %h", i,
                         e_if.err, e_if.para_0, e_if.para_1, e_if.para_2, m_err[19:0],
                         m_w0[15:0], m_w1[15:0], m_w2[15:0]);
                miscompares++;
            end
        end
    endtask

    // Continues from test_echo without reset
    task automatic test_enable_hold();
        int m_w0;
        int m_w1;
        int m_w2;
        @(negedge clk);
        set_en(1'b0);
        for (int i = 0; i < 22; i++) begin
            if (i == 10) begin
                @(negedge clk);
                set_en(1'b1);
            end
            if (i >= 10) model_step();
            tick();
            m_w0 = m_w[0];
            m_w1 = m_w[1];
            m_w2 = m_w[2];
            vectors++;
            if (e_if.signal_random !== m_q || e_if.signal_lag !== m_y[19:0] ||
                e_if.err !== m_err[19:0] || e_if.para_0 !== m_w0[15:0] ||
                e_if.para_1 !== m_w1[15:0] || e_if.para_2 !== m_w2[15:0]) begin
                $display("FAIL hold_cyc%0d: got x=%h y=%h e=%h w=%h %h %h want %h %h %h %h %h %h",
                         i, e_if.signal_random, e_if.signal_lag, e_if.err, e_if.para_0,
                         e_if.para_1, e_if.para_2, m_q, m_y[19:0], m_err[19:0], m_w0[15:0],
                         m_w1[15:0], m_w2[15:0]);
                miscompares++;
            end
        end
    endtask

    task automatic test_convergence();
        logic hit_zero;
        int   p0;
        int   p1;
        int   p2;
        hit_zero = 1'b0;
        apply_reset();
        for (int i = 0; i < 20000; i++) begin
            tick();
            if (e_if.signal_random == 16'h0) hit_zero = 1'b1;
        end
        vectors++;
        if (hit_zero !== 1'b0) begin
            $display("FAIL lfsr_nonzero: got zero state, want never zero");
            miscompares++;
        end
        p0 = int'($signed(e_if.para_0));
        p1 = int'($signed(e_if.para_1));
        p2 = int'($signed(e_if.para_2));
        vectors++;
        if (p0 < 4032 || p0 > 4160) begin
            $display("FAIL conv_para0: got %0d want 4096+-64", p0);
            miscompares++;
        end
        vectors++;
        if (p1 < 8128 || p1 > 8256) begin
            $display("FAIL conv_para1: got %0d want 8192+-64", p1);
            miscompares++;
        end
        vectors++;
        if (p2 < -4160 || p2 > -4032) begin
            $display("FAIL conv_para2: got %0d want -4096+-64", p2);
            miscompares++;
        end
    endtask

    task automatic test_zero_echo();
        apply_reset();
        for (int i = 0; i < 64; i++) begin
            tick();
            vectors++;
            if (z_if.signal_lag !== 20'h0 || z_if.err !== 20'h0 || z_if.para_0 !== 16'h0 ||
                z_if.para_1 !== 16'h0 || z_if.para_2 !== 16'h0) begin
                $display("FAIL zero_cyc%0d: got y=%h e=%h w=%h %h %h want all 0", i,
                         z_if.signal_lag, z_if.err, z_if.para_0, z_if.para_1, z_if.para_2);
                miscompares++;
            end
        end
    endtask

    initial begin
        set_en(1'b0);
        model_reset();
        test_reset();
        test_lfsr();
        test_latency();
        test_echo();
        test_enable_hold();
        test_zero_echo();
        test_convergence();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
